// File: rtl/pal_reg_engine.sv
// pal_reg_engine: runtime-programmable registered-output PAL with downloadable fuse map
// Ports: clk/reset (sync, active-high); load_en/load_wr/load_data/load_done fuse download;
// strobe/din register-clock request and inputs; oe/dout bus read; q raw registers;
// busy evaluation in progress; overrun sticky lost-event flag.
module pal_reg_engine #(
  parameter int N_IN = 8,
  parameter int N_OUT = 8,
  parameter int N_TERMS = 8,
  parameter logic [N_OUT-1:0] OUT_INV = {N_OUT{1'b1}},
  parameter logic [N_OUT-1:0] RESET_VAL = {N_OUT{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic             load_wr,
  input  logic [7:0]       load_data,
  output logic             load_done,
  input  logic             strobe,
  input  logic [N_IN-1:0]  din,
  input  logic             oe,
  output logic [N_OUT-1:0] dout,
  output logic [N_OUT-1:0] q,
  output logic             busy,
  output logic             overrun
);
  localparam int W = N_IN + N_OUT;
  localparam int FW = 2 * W;
  localparam int WB = FW / 8;
  localparam int KW = N_OUT > 1 ? $clog2(N_OUT) : 1;
  localparam int TW = N_TERMS > 1 ? $clog2(N_TERMS) : 1;
  localparam int BW = WB > 1 ? $clog2(WB) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  logic [FW-1:0] r_fuse [N_OUT][N_TERMS];
  logic [1:0] r_state;
  logic [TW-1:0] r_t;
  logic [N_IN-1:0] r_din, r_pend_din;
  logic [N_OUT-1:0] r_snap, r_acc, r_q;
  logic r_pend, r_overrun, r_strobe_d, r_load_en_d, r_done;
  logic [KW-1:0] r_lk;
  logic [TW-1:0] r_lt;
  logic [BW-1:0] r_lb;
  logic w_ld_rise, w_st_rise, w_done, w_wr, w_last_b, w_last_t, w_last;
  logic [KW-1:0] w_lk;
  logic [TW-1:0] w_lt;
  logic [BW-1:0] w_lb;
  logic [FW-1:0] w_mask, w_wbyte;
  logic [W-1:0] w_lit;
  logic [N_OUT-1:0] w_term, w_new_q;
  assign w_ld_rise = load_en & ~r_load_en_d;
  assign w_st_rise = strobe & ~r_strobe_d & ~load_en;
  // a load_en rise and a write in the same cycle target byte 0
  assign w_lk = w_ld_rise ? '0 : r_lk;
  assign w_lt = w_ld_rise ? '0 : r_lt;
  assign w_lb = w_ld_rise ? '0 : r_lb;
  assign w_done = ~w_ld_rise & r_done;
  assign w_wr = load_en & load_wr & ~w_done;
  assign w_last_b = w_lb == BW'(WB - 1);
  assign w_last_t = w_lt == TW'(N_TERMS - 1);
  assign w_last = w_last_b & w_last_t & (w_lk == KW'(N_OUT - 1));
  assign w_mask = {{(FW-8){1'b0}}, 8'hFF} << {w_lb, 3'b000};
  assign w_wbyte = {{(FW-8){1'b0}}, load_data} << {w_lb, 3'b000};
  assign w_lit = {r_snap, r_din};
  assign w_new_q = r_acc ^ OUT_INV;
  for (genvar k = 0; k < N_OUT; k++) begin : g_term
    logic [FW-1:0] w_word;
    assign w_word = r_fuse[k][r_t];
    // both-polarity enables are self-cancelling: no literal satisfies x & ~x
    assign w_term[k] = (|w_word) & ((w_lit & w_word[W-1:0]) == w_word[W-1:0])
                     & ((~w_lit & w_word[FW-1:W]) == w_word[FW-1:W]);
  end
  always_ff @(posedge clk)
    if (w_wr) r_fuse[w_lk][w_lt] <= (r_fuse[w_lk][w_lt] & ~w_mask) | w_wbyte;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_t <= '0;
      r_din <= '0;
      r_pend_din <= '0;
      r_snap <= '0;
      r_acc <= '0;
      r_q <= RESET_VAL;
      r_pend <= 1'b0;
      r_overrun <= 1'b0;
      r_strobe_d <= 1'b0;
      r_load_en_d <= 1'b0;
      r_done <= 1'b0;
      r_lk <= '0;
      r_lt <= '0;
      r_lb <= '0;
    end else begin
      r_strobe_d <= strobe;
      r_load_en_d <= load_en;
      if (w_wr) begin
        r_lb <= w_last_b ? '0 : w_lb + 1'b1;
        r_lt <= w_last_b ? (w_last_t ? '0 : w_lt + 1'b1) : w_lt;
        r_lk <= (w_last_b & w_last_t) ? w_lk + 1'b1 : w_lk;
        r_done <= w_last;
      end else if (w_ld_rise) begin
        r_lk <= '0;
        r_lt <= '0;
        r_lb <= '0;
        r_done <= 1'b0;
      end
      if (w_ld_rise && r_state != S_IDLE) begin
        r_state <= S_IDLE;
        r_pend <= 1'b0;
      end else if (r_state == S_IDLE) begin
        if (w_st_rise) begin
          r_din <= din;
          r_snap <= r_q;
          r_acc <= '0;
          r_t <= '0;
          r_state <= S_EVAL;
        end
      end else if (r_state == S_EVAL) begin
        r_acc <= r_acc | w_term;
        r_t <= r_t + 1'b1;
        if (r_t == TW'(N_TERMS - 1)) r_state <= S_COMMIT;
        if (w_st_rise) begin
          r_pend <= 1'b1;
          r_pend_din <= din;
          if (r_pend) r_overrun <= 1'b1;
        end
      end else begin
        // a rise in this cycle chains straight into EVAL against the fresh q
        r_q <= w_new_q;
        r_snap <= w_new_q;
        r_acc <= '0;
        r_t <= '0;
        r_state <= (r_pend | w_st_rise) ? S_EVAL : S_IDLE;
        r_din <= r_pend ? r_pend_din : din;
        r_pend <= r_pend & w_st_rise;
        if (w_st_rise) r_pend_din <= din;
      end
    end
  end
  assign load_done = r_done;
  assign q = r_q;
  assign dout = oe ? r_q : '1;
  assign busy = r_state != S_IDLE;
  assign overrun = r_overrun;
endmodule
